board_link_mux: RTL and testbench
=================================

// Module: board_link_mux
// PURPOSE
//  Parametrised two-board Pmod link endpoint. Successor to the fixed 8-pin master/slave pin setter.
//  Master role: drives the local OLED SPI bundle out and receives the remote player's buttons.
//  Slave role: drives its local buttons out and receives the master's OLED bundle for its own screen.
//  Adds input synchronisers, a guarded role switch, a heartbeat link watchdog and optional button debounce.
// PARAMETERS
//  PIN_W       8        link pins per direction (tx on jxadc, rx on ja); >= max(OLED_W,BTN_W)+1
//  OLED_W      7        OLED bundle width: cs,sdin,sclk,d_cn,resn,vccen,pmoden (bit0..6)
//  BTN_W       5        button bundle width: up,down,left,right,attack/centre (bit0..4)
//  GUARD_CYC   16       cycles with all tx and rx outputs forced low after a role change
//  HB_DIV      1024     heartbeat half-period in clk cycles
//  TIMEOUT_CYC 8192     rx heartbeat silence (cycles) that drops link_up; must exceed 2*HB_DIV
//  DB_CYC      65536    debounce stability window in cycles (BTN_DEBOUNCE_EN only)
// PORTS
//  clk         in  1       system clock
//  rst         in  1       synchronous active-high reset
//  is_master   in  1       role select (switch); sampled every cycle
//  oled_in     in  OLED_W  local OLED driver outputs (used in master role)
//  btn_in      in  BTN_W   local buttons (used in slave role)
//  ja          in  PIN_W   rx link pins
//  jxadc       out PIN_W   tx link pins; bit PIN_W-1 = heartbeat
//  remote_btn  out BTN_W   remote player buttons (master role, else 0)
//  slave_oled  out OLED_W  OLED bundle for the local screen (slave role, else 0)
//  link_up     out 1       remote heartbeat present
//  role_q      out 1       role currently in effect (1 = master)
//  guard       out 1       role switch in progress
// BEHAVIOUR
//  - Reset: jxadc=0, remote_btn=0, slave_oled=0, link_up=0, guard=1, role_q=is_master, FSM=GUARD.
//    Guard counter=0, heartbeat divider=0, watchdog=0, sync and debounce flops=0.
//  - FSM GUARD: all outputs except guard and role_q are held 0; counter runs to GUARD_CYC-1, then ACTIVE.
//  - FSM ACTIVE: when is_master != role_q, next cycle role_q<=is_master and FSM enters GUARD.
//    Entering GUARD clears the guard counter, heartbeat divider, watchdog and link_up.
//    A second toggle during GUARD updates role_q and restarts the count.
//  - rx path: every ja bit passes through a 2-flop synchroniser, so all rx bits see equal 2-cycle latency.
//    Equal latency keeps SPI cs/sclk/sdin skew-free.
//  - tx path: jxadc[OLED_W-1:0]=oled_in (master) or jxadc[BTN_W-1:0]=btn_in (slave).
//    tx is registered, 1-cycle latency; unused tx bits are driven 0.
//  - Heartbeat: in ACTIVE, jxadc[PIN_W-1] toggles every HB_DIV cycles; the first toggle comes HB_DIV cycles after entering ACTIVE.
//  - Watchdog: counts cycles since the last edge on the synced ja[PIN_W-1] and saturates at TIMEOUT_CYC.
//    An edge clears the count and sets link_up=1 on the next cycle.
//    The count reaching TIMEOUT_CYC clears link_up on that same cycle.
//  - rx gating: remote_btn = synced/debounced ja[BTN_W-1:0] only when role_q=1 && link_up && !guard, else 0.
//    slave_oled = synced ja[OLED_W-1:0] only when role_q=0 && link_up && !guard, else 0.
//    Forcing resn=0 here holds the slave OLED in reset.
//  - link_up falling clears the outputs in the same cycle: no stale button or OLED state is held.
//  - Role change while a button is held: remote_btn goes 0 immediately in GUARD. It returns only after a fresh remote heartbeat edge.
// CONFIGURATION
//  - BTN_DEBOUNCE_EN defined: each remote_btn bit has its own counter. The output takes the synced value only after it has differed from the current output for DB_CYC consecutive cycles.
//    Any bounce restarts the counter. Counters clear in GUARD and on link_up=0.
//  - BTN_DEBOUNCE_EN undefined: remote_btn is the synced value (2-cycle latency) and no debounce logic is built.
//    slave_oled is never debounced in either build.
// TESTING
//  Bench params: PIN_W=8, OLED_W=7, BTN_W=5, GUARD_CYC=4, HB_DIV=8, TIMEOUT_CYC=32, DB_CYC=5.
//  1 Reset and role hold: rst 3 cycles, is_master=1 -> all outputs 0 and guard=1 for 4 cycles after rst low.
//    jxadc[7] first toggles 8 cycles after ACTIVE.
//  2 Link up and master rx: ja[7] toggles every 8 cycles with ja[4:0]=5'b10101 -> link_up=1 by 3 cycles after the first edge.
//    remote_btn=5'b10101 (undebounced) 2 cycles after ja settles.
//  3 Timeout: stop ja[7] toggles -> link_up=0 exactly 32 cycles after the last synced edge, and remote_btn=0 in the same cycle.
//  4 Role switch: is_master 1->0 while ACTIVE -> role_q=0 next cycle, guard=1 for 4 cycles with jxadc=0.
//    Then jxadc[4:0] follows btn_in with 1-cycle lag; slave_oled mirrors ja[6:0] once link_up.
//  5 Debounce (BTN_DEBOUNCE_EN): ja[0] pulses 3 cycles -> remote_btn[0] stays 0.
//    ja[0] held 7 cycles -> remote_btn[0]=1 after 2+5 cycles.
//  6 Mid-guard toggle: is_master toggles twice within GUARD -> guard count restarts each time.
//    role_q ends at the last is_master value; no heartbeat edge appears during GUARD.

Source files
------------

// File: rtl/board_link_mux.sv
// board_link_mux: two-board Pmod link endpoint, master sends its OLED bundle, slave sends its buttons
// Optional build macro: BTN_DEBOUNCE_EN (per-bit debounce on remote_btn)
// Ports:
//   clk, rst    system clock, synchronous active-high reset
//   is_master   role select (1 = master), sampled every cycle
//   oled_in     local OLED bundle, transmitted in master role
//   btn_in      local buttons, transmitted in slave role
//   ja          rx link pins, ja[PIN_W-1] carries the remote heartbeat
//   jxadc       tx link pins, jxadc[PIN_W-1] carries the local heartbeat
//   remote_btn  remote buttons (master role, live link, no guard), else 0
//   slave_oled  OLED bundle from the master (slave role, live link, no guard), else 0
//   link_up     remote heartbeat present
//   role_q      role in effect (1 = master)
//   guard       role switch in progress, all link outputs held low
module board_link_mux #(
    parameter int PIN_W       = 8,
    parameter int OLED_W      = 7,
    parameter int BTN_W       = 5,
    parameter int GUARD_CYC   = 16,
    parameter int HB_DIV      = 1024,
    parameter int TIMEOUT_CYC = 8192,
    parameter int DB_CYC      = 65536
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              is_master,
    input  logic [OLED_W-1:0] oled_in,
    input  logic [BTN_W-1:0]  btn_in,
    input  logic [PIN_W-1:0]  ja,
    output logic [PIN_W-1:0]  jxadc,
    output logic [BTN_W-1:0]  remote_btn,
    output logic [OLED_W-1:0] slave_oled,
    output logic              link_up,
    output logic              role_q,
    output logic              guard
);
    localparam int GW = $clog2(GUARD_CYC + 1);
    localparam int HW = $clog2(HB_DIV + 1);
    localparam int WW = $clog2(TIMEOUT_CYC + 1);

    if (PIN_W < ((OLED_W > BTN_W) ? OLED_W : BTN_W) + 1) begin : g_bad_pin_w
        $error("PIN_W must leave a spare pin for the heartbeat");
    end
    if (TIMEOUT_CYC <= 2 * HB_DIV) begin : g_bad_timeout
        $error("TIMEOUT_CYC must exceed two heartbeat half-periods");
    end
    if (GUARD_CYC < 1 || HB_DIV < 1 || DB_CYC < 1) begin : g_bad_cyc
        $error("cycle parameters must be positive");
    end

    typedef enum logic {GUARD, ACTIVE} state_t;

    state_t            state, state_nxt;
    logic              role_nxt;
    logic [GW-1:0]     guard_cnt, guard_cnt_nxt;
    logic [HW-1:0]     hb_cnt;
    logic              hb_tick;
    logic [WW-1:0]     wd_cnt;
    logic              link_q;
    logic [PIN_W-1:0]  rx_s1, rx_s2;
    logic              hb_prev, rx_edge, rx_open;
    logic [PIN_W-1:0]  tx_nxt;
    logic [BTN_W-1:0]  btn_rx;

    always_comb begin
        role_nxt      = role_q;
        state_nxt     = state;
        guard_cnt_nxt = (state == GUARD) ? guard_cnt + 1'b1 : '0;
        if (is_master != role_q) begin
            role_nxt      = is_master;
            state_nxt     = GUARD;
            guard_cnt_nxt = '0;
        end else if (state == GUARD && guard_cnt == GW'(GUARD_CYC - 1)) begin
            state_nxt = ACTIVE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= GUARD;
            role_q    <= is_master;
            guard_cnt <= '0;
        end else begin
            state     <= state_nxt;
            role_q    <= role_nxt;
            guard_cnt <= guard_cnt_nxt;
        end
    end

    assign guard = (state == GUARD);

    // Every rx bit takes the same two-flop path so the SPI bundle stays skew-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1   <= '0;
            rx_s2   <= '0;
            hb_prev <= 1'b0;
        end else begin
            rx_s1   <= ja;
            rx_s2   <= rx_s1;
            hb_prev <= rx_s2[PIN_W-1];
        end
    end

    assign rx_edge = rx_s2[PIN_W-1] ^ hb_prev;
    assign hb_tick = (state == ACTIVE) && (hb_cnt == HW'(HB_DIV - 1));

    always_comb begin
        tx_nxt = '0;
        if (role_q) tx_nxt[OLED_W-1:0] = oled_in;
        else        tx_nxt[BTN_W-1:0]  = btn_in;
        tx_nxt[PIN_W-1] = jxadc[PIN_W-1] ^ hb_tick;
    end

    // Keyed on the next state so the first GUARD cycle already shows an all-low link.
    always_ff @(posedge clk) begin
        if (rst || state_nxt == GUARD) begin
            jxadc  <= '0;
            hb_cnt <= '0;
        end else begin
            jxadc  <= tx_nxt;
            hb_cnt <= (state == ACTIVE && !hb_tick) ? hb_cnt + 1'b1 : '0;
        end
    end

    // link_q drops on the same edge that brings the count to TIMEOUT_CYC.
    always_ff @(posedge clk) begin
        if (rst || state_nxt == GUARD) begin
            wd_cnt <= '0;
            link_q <= 1'b0;
        end else begin
            wd_cnt <= rx_edge ? '0 : (wd_cnt == WW'(TIMEOUT_CYC)) ? wd_cnt : wd_cnt + 1'b1;
            link_q <= rx_edge || (link_q && wd_cnt < WW'(TIMEOUT_CYC - 1));
        end
    end

    assign link_up = link_q;
    assign rx_open = link_q && !guard;

`ifdef BTN_DEBOUNCE_EN
    localparam int DW = $clog2(DB_CYC + 1);
    for (genvar i = 0; i < BTN_W; i++) begin : g_db
        logic [DW-1:0] cnt;
        logic          q;
        always_ff @(posedge clk) begin
            if (rst || !rx_open) begin
                cnt <= '0;
                q   <= 1'b0;
            end else if (rx_s2[i] == q) begin
                cnt <= '0;
            end else if (cnt == DW'(DB_CYC - 1)) begin
                cnt <= '0;
                q   <= rx_s2[i];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
        assign btn_rx[i] = q;
    end
`else
    assign btn_rx = rx_s2[BTN_W-1:0];
`endif

    // Zero on a dead link so a held button or a live OLED never outlives the partner;
    // a zero OLED bundle keeps resn low and the slave screen in reset.
    assign remote_btn = (role_q && rx_open) ? btn_rx : '0;
    assign slave_oled = (!role_q && rx_open) ? rx_s2[OLED_W-1:0] : '0;
endmodule

// File: tb/tb_board_link_mux.sv
// tb_board_link_mux: scoreboard bench for board_link_mux
module tb_board_link_mux;
`ifdef BTN_DEBOUNCE_EN
    localparam int DB_X = 5;
`else
    localparam int DB_X = 0;
`endif
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       is_master = 1'b1;
    logic [6:0] oled_in = '0;
    logic [4:0] btn_in = '0;
    logic [7:0] ja = '0;
    logic [7:0] jxadc;
    logic [4:0] remote_btn;
    logic [6:0] slave_oled;
    logic       link_up, role_q, guard;
    int         n_checks = 0;
    int         n_pass = 0;
    int         hb_ph = 0;
    bit         hb_on = 1'b0;
    logic [7:0] exp_q[$];

    board_link_mux #(
        .PIN_W(8), .OLED_W(7), .BTN_W(5), .GUARD_CYC(4),
        .HB_DIV(8), .TIMEOUT_CYC(32), .DB_CYC(5)
    ) dut (
        .clk(clk), .rst(rst), .is_master(is_master), .oled_in(oled_in), .btn_in(btn_in),
        .ja(ja), .jxadc(jxadc), .remote_btn(remote_btn), .slave_oled(slave_oled),
        .link_up(link_up), .role_q(role_q), .guard(guard)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
        if (hb_on) begin
            hb_ph++;
            if (hb_ph == 8) begin
                hb_ph = 0;
                ja[7] = ~ja[7];
            end
        end
    endtask

    task automatic start_hb();
        ja[7] = ~ja[7];
        hb_ph = 0;
        hb_on = 1'b1;
    endtask

    task automatic wait_link(input string tag);
        int n = 0;
        while (link_up !== 1'b1 && n < 40) begin
            cyc();
            n++;
        end
        n_checks++; if (link_up !== 1'b1) $display("FAIL %s link_up=%b after %0d cycles, want 1", tag, link_up, n); else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        is_master = 1'b1;
        repeat (3) cyc();
        n_checks++; if (jxadc !== 8'h00 || remote_btn !== 5'h00 || slave_oled !== 7'h00 || link_up !== 1'b0)
            $display("FAIL reset_outputs jxadc=%h remote_btn=%h slave_oled=%h link_up=%b, want all 0", jxadc, remote_btn, slave_oled, link_up); else n_pass++;
        n_checks++; if (guard !== 1'b1 || role_q !== 1'b1) $display("FAIL reset_role guard=%b role_q=%b, want 1 1", guard, role_q); else n_pass++;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (guard !== 1'b1 || jxadc !== 8'h00 || link_up !== 1'b0)
                $display("FAIL guard_hold[%0d] guard=%b jxadc=%h link_up=%b, want 1 00 0", i, guard, jxadc, link_up); else n_pass++;
            cyc();
        end
        n_checks++; if (guard !== 1'b0) $display("FAIL guard_release guard=%b, want 0", guard); else n_pass++;
    endtask

    task automatic test_tx_master();
        logic [7:0] e;
        for (int k = 1; k <= 8; k++) begin
            oled_in = 7'($urandom_range(0, 127));
            exp_q.push_back({k == 8, oled_in});
            cyc();
            e = exp_q.pop_front();
            n_checks++; if (jxadc !== e) $display("FAIL tx_master[%0d] jxadc=%h, want %h", k, jxadc, e); else n_pass++;
        end
    endtask

    task automatic test_link_master();
        logic [7:0] e;
        ja[4:0] = 5'b10101;
        exp_q.push_back({3'b0, 5'b10101});
        start_hb();
        repeat (2) cyc();
        n_checks++; if (link_up !== 1'b0 || remote_btn !== 5'h00) $display("FAIL link_early link_up=%b remote_btn=%b, want 0 00000", link_up, remote_btn); else n_pass++;
        cyc();
        n_checks++; if (link_up !== 1'b1) $display("FAIL link_rise link_up=%b, want 1", link_up); else n_pass++;
        repeat (DB_X) cyc();
        e = exp_q.pop_front();
        n_checks++; if (remote_btn !== e[4:0]) $display("FAIL master_rx remote_btn=%b, want %b", remote_btn, e[4:0]); else n_pass++;
        n_checks++; if (slave_oled !== 7'h00) $display("FAIL slave_oled_master slave_oled=%h, want 00", slave_oled); else n_pass++;
        ja[4:0] = 5'b01010;
        exp_q.push_back({3'b0, 5'b01010});
        cyc();
        n_checks++; if (remote_btn !== 5'b10101) $display("FAIL rx_latency remote_btn=%b, want 10101", remote_btn); else n_pass++;
        cyc();
        repeat (DB_X) cyc();
        e = exp_q.pop_front();
        n_checks++; if (remote_btn !== e[4:0]) $display("FAIL master_rx2 remote_btn=%b, want %b", remote_btn, e[4:0]); else n_pass++;
    endtask

    task automatic test_timeout();
        int n = 0;
        do begin
            cyc();
            n++;
        end while (hb_ph != 0 && n < 16);
        hb_on = 1'b0;
        // two sync flops, one edge-register cycle, then 32 counted cycles
        repeat (34) cyc();
        n_checks++; if (link_up !== 1'b1 || remote_btn !== 5'b01010) $display("FAIL timeout_before link_up=%b remote_btn=%b, want 1 01010", link_up, remote_btn); else n_pass++;
        cyc();
        n_checks++; if (link_up !== 1'b0 || remote_btn !== 5'h00) $display("FAIL timeout_drop link_up=%b remote_btn=%b, want 0 00000", link_up, remote_btn); else n_pass++;
    endtask

    task automatic test_role_switch();
        logic [7:0] e;
        ja[6:0] = 7'h2B;
        start_hb();
        wait_link("link_resume");
        repeat (DB_X) cyc();
        n_checks++; if (remote_btn !== 5'h0B) $display("FAIL resume_rx remote_btn=%h, want 0b", remote_btn); else n_pass++;
        btn_in = 5'h13;
        is_master = 1'b0;
        cyc();
        n_checks++; if (role_q !== 1'b0 || guard !== 1'b1 || jxadc !== 8'h00 || remote_btn !== 5'h00 || link_up !== 1'b0)
            $display("FAIL switch_enter role_q=%b guard=%b jxadc=%h remote_btn=%h link_up=%b, want 0 1 00 00 0", role_q, guard, jxadc, remote_btn, link_up); else n_pass++;
        for (int i = 1; i < 4; i++) begin
            cyc();
            n_checks++; if (guard !== 1'b1 || jxadc !== 8'h00) $display("FAIL switch_guard[%0d] guard=%b jxadc=%h, want 1 00", i, guard, jxadc); else n_pass++;
        end
        cyc();
        n_checks++; if (guard !== 1'b0 || jxadc[6:0] !== 7'h13) $display("FAIL switch_active guard=%b jxadc[6:0]=%h, want 0 13", guard, jxadc[6:0]); else n_pass++;
        for (int k = 0; k < 6; k++) begin
            btn_in = 5'($urandom_range(0, 31));
            exp_q.push_back({3'b0, btn_in});
            cyc();
            e = exp_q.pop_front();
            n_checks++; if (jxadc[6:0] !== {2'b00, e[4:0]}) $display("FAIL tx_slave[%0d] jxadc[6:0]=%h, want %h", k, jxadc[6:0], {2'b00, e[4:0]}); else n_pass++;
        end
        wait_link("link_slave");
        n_checks++; if (slave_oled !== 7'h2B || remote_btn !== 5'h00) $display("FAIL slave_rx slave_oled=%h remote_btn=%h, want 2b 00", slave_oled, remote_btn); else n_pass++;
        ja[6:0] = 7'h66;
        exp_q.push_back({1'b0, 7'h66});
        cyc();
        n_checks++; if (slave_oled !== 7'h2B) $display("FAIL slave_latency slave_oled=%h, want 2b", slave_oled); else n_pass++;
        cyc();
        e = exp_q.pop_front();
        n_checks++; if (slave_oled !== e[6:0]) $display("FAIL slave_rx2 slave_oled=%h, want %h", slave_oled, e[6:0]); else n_pass++;
    endtask

    task automatic test_mid_guard();
        is_master = 1'b1;
        cyc();
        n_checks++; if (role_q !== 1'b1 || guard !== 1'b1 || jxadc !== 8'h00 || slave_oled !== 7'h00)
            $display("FAIL mid_enter role_q=%b guard=%b jxadc=%h slave_oled=%h, want 1 1 00 00", role_q, guard, jxadc, slave_oled); else n_pass++;
        repeat (2) cyc();
        is_master = 1'b0;
        cyc();
        n_checks++; if (role_q !== 1'b0 || guard !== 1'b1) $display("FAIL mid_toggle1 role_q=%b guard=%b, want 0 1", role_q, guard); else n_pass++;
        cyc();
        n_checks++; if (guard !== 1'b1) $display("FAIL mid_restart1 guard=%b, want 1", guard); else n_pass++;
        is_master = 1'b1;
        cyc();
        n_checks++; if (role_q !== 1'b1 || guard !== 1'b1) $display("FAIL mid_toggle2 role_q=%b guard=%b, want 1 1", role_q, guard); else n_pass++;
        for (int i = 1; i < 4; i++) begin
            cyc();
            n_checks++; if (guard !== 1'b1 || jxadc !== 8'h00) $display("FAIL mid_guard[%0d] guard=%b jxadc=%h, want 1 00", i, guard, jxadc); else n_pass++;
        end
        cyc();
        n_checks++; if (guard !== 1'b0 || role_q !== 1'b1 || jxadc[7] !== 1'b0) $display("FAIL mid_active guard=%b role_q=%b hb=%b, want 0 1 0", guard, role_q, jxadc[7]); else n_pass++;
    endtask

    task automatic test_btn_filter();
        logic [7:0] e;
        logic       want;
        wait_link("link_master_again");
        ja[4:0] = 5'h00;
        repeat (4 + DB_X) cyc();
        n_checks++; if (remote_btn !== 5'h00) $display("FAIL pulse_idle remote_btn=%b, want 00000", remote_btn); else n_pass++;
        exp_q.push_back(8'h00);
        for (int k = 0; k < 10; k++) begin
            ja[0] = (k < 3);
            exp_q.push_back({7'b0, ja[0]});
            cyc();
            e = exp_q.pop_front();
            want = (DB_X == 0) ? e[0] : 1'b0;
            n_checks++; if (remote_btn[0] !== want) $display("FAIL pulse[%0d] remote_btn[0]=%b, want %b", k, remote_btn[0], want); else n_pass++;
        end
        exp_q.delete();
        for (int k = 0; k < 8; k++) begin
            ja[0] = 1'b1;
            want = (k >= 1 + DB_X);
            cyc();
            n_checks++; if (remote_btn[0] !== want) $display("FAIL hold[%0d] remote_btn[0]=%b, want %b", k, remote_btn[0], want); else n_pass++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_tx_master();
        test_link_master();
        test_timeout();
        test_role_switch();
        test_mid_guard();
        test_btn_filter();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
